// File: rtl/mem_copy_pkg.sv
// Shared definitions for the word-copy engine: FSM encoding, address width and word stride.
package mem_copy_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned WORD_STRIDE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } copy_state_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: one load then one store per word, ascending addresses.
// Optional MEM_COPY_FILL_EN adds a store-only fill mode (fill / fill_value ports).
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int unsigned LEN_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
`ifdef MEM_COPY_FILL_EN
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_value,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] Write_data,
   input  logic [DATA_W-1:0] Read_data,
   output logic              MemRead,
   output logic              MemWrite
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

   copy_state_t       state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [LEN_W-1:0]  count;
   logic [DATA_W-1:0] data_reg;
`ifdef MEM_COPY_FILL_EN
   logic              fill_mode;
`endif

   // Store data is only presented during the write phase.
   assign Write_data = MemWrite ? data_reg : '0;

   // Outputs are registered: each transition sets up the bus for the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         count     <= '0;
         data_reg  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         Address   <= '0;
         MemRead   <= 1'b0;
         MemWrite  <= 1'b0;
`ifdef MEM_COPY_FILL_EN
         fill_mode <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (len != '0) begin
                     src_ptr <= word_align(src_addr);
                     dst_ptr <= word_align(dst_addr);
                     count   <= len;
                     busy    <= 1'b1;
`ifdef MEM_COPY_FILL_EN
                     fill_mode <= fill;
                     if (fill) begin
                        data_reg <= fill_value;
                        MemWrite <= 1'b1;
                        Address  <= word_align(dst_addr);
                        state    <= WR;
                     end else begin
                        MemRead <= 1'b1;
                        Address <= word_align(src_addr);
                        state   <= RD;
                     end
`else
                     MemRead <= 1'b1;
                     Address <= word_align(src_addr);
                     state   <= RD;
`endif
                  end else begin
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end
            end
            RD: begin
               data_reg <= Read_data;
               MemRead  <= 1'b0;
               MemWrite <= 1'b1;
               Address  <= dst_ptr;
               state    <= WR;
            end
            WR: begin
               src_ptr  <= src_ptr + STRIDE;
               dst_ptr  <= dst_ptr + STRIDE;
               count    <= count - LEN_W'(1);
               MemWrite <= 1'b0;
               if (count == LEN_W'(1)) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  Address <= '0;
                  state   <= FIN;
`ifdef MEM_COPY_FILL_EN
               end else if (fill_mode) begin
                  MemWrite <= 1'b1;
                  Address  <= dst_ptr + STRIDE;
                  state    <= WR;
`endif
               end else begin
                  MemRead <= 1'b1;
                  Address <= src_ptr + STRIDE;
                  state   <= RD;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the word-count input and the remaining-count register.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a copy, sampled only in IDLE.
REQ-005 SHALL have port src_addr  input  32  byte address of the first source word.
REQ-006 SHALL have port dst_addr  input  32  byte address of the first destination word.
REQ-007 SHALL have port len  input  LEN_W  number of 32-bit words to copy.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until the done pulse.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port Address  output  32  word-aligned memory address.
REQ-011 SHALL have port Write_data  output  32  store data.
REQ-012 SHALL have port Read_data  input  32  combinational load data from memory.
REQ-013 SHALL have port MemRead  output  1  load enable.
REQ-014 SHALL have port MemWrite  output  1  store enable, committed by memory at the next rising clk.

Function
REQ-015 SHALL implement states IDLE, RD, WR and FIN.
REQ-016 In IDLE with start=1 and len!=0, the engine SHALL latch src_addr, dst_addr and len with bits [1:0] of both addresses forced to 0, then go to RD.
REQ-017 In IDLE with start=1 and len=0, the engine SHALL go to FIN with no memory access.
REQ-018 In RD, the engine SHALL drive MemRead=1 and Address=current source, capture Read_data into the data register at the clock edge, and go to WR.
REQ-019 In WR, the engine SHALL drive MemWrite=1, Address=current destination and Write_data=data register.
REQ-020 At the clock edge leaving WR, the engine SHALL add 4 to both pointers and decrement the remaining count, going to FIN if the count was 1 and to RD otherwise.
REQ-021 Each word SHALL take exactly 2 cycles; done SHALL assert in FIN, exactly 2*len+1 cycles after the start cycle, and FIN SHALL return to IDLE.
REQ-022 MemRead and MemWrite SHALL never be high in the same cycle; both SHALL be 0 in IDLE and FIN; Address and Write_data SHALL be 0 outside RD/WR.
REQ-023 Pointer increments SHALL wrap modulo 2^32, e.g. 0xFFFFFFFC+4=0x00000000.
REQ-024 start while busy=1 SHALL be ignored; input changes after the start cycle SHALL have no effect.
REQ-025 Overlapping regions SHALL have ascending word-by-word semantics, so each read observes all earlier writes.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE and clear the pointers, count, data register, busy, done, MemRead and MemWrite.
REQ-027 Reset mid-copy SHALL abort with no further access and no done pulse; words already written SHALL remain.

Configuration
REQ-028 With macro MEM_COPY_FILL_EN defined, the engine SHALL add inputs fill (1 bit) and fill_value (32 bits), both sampled with start.
REQ-029 With MEM_COPY_FILL_EN defined and fill=1, the engine SHALL skip RD and perform only WR of fill_value, taking 1 cycle per word, with done asserting len+1 cycles after start.
REQ-030 Without MEM_COPY_FILL_EN, the fill ports and the fill path SHALL be absent, and behaviour SHALL be copy-only.

Structure
REQ-031 The shared package mem_copy_pkg SHALL hold the state encoding, the word-stride constant (4) and the address width (32).
REQ-032 The design SHALL be a single flat module with no sub-module.

Verification
REQ-033 Bench memory preloaded 0x10..0x1C={A,B,C,D}; start with src=0x10, dst=0x40, len=4 -> 0x40..0x4C={A,B,C,D}, done at cycle 9, busy high for cycles 1-8.
REQ-034 start with len=0 -> done in the next cycle, MemRead and MemWrite never asserted.
REQ-035 src=0x13, dst=0xFFFFFFFE, len=2 -> reads from 0x10 and 0x14, writes to 0xFFFFFFFC and 0x00000000.
REQ-036 Overlap src=0x0, dst=0x4, len=3, memory[0]=0x11 -> words 1..3 all become 0x11.
REQ-037 start held high for 3 cycles -> exactly one copy; reset=0 asserted in cycle 3 of a len=4 copy -> only word 0 written, no done pulse.
REQ-038 With MEM_COPY_FILL_EN defined: fill=1, fill_value=0xDEADBEEF, dst=0x80, len=3 -> three stores, no loads, done at cycle 4.
